// File: rtl/rf_scoreboard_pkg.sv
// rf_scoreboard_pkg: shared sizes and FSM state encodings for the register-file scoreboard
package rf_scoreboard_pkg;
  localparam int NUM_RF = 16;
  localparam int IDX_WIDTH = 4;
  localparam int CNT_WIDTH = 2;
  localparam logic [0:0] SB_IDLE = 1'b0;
  localparam logic [0:0] SB_BR_WAIT = 1'b1;
endpackage

// File: rtl/rf_scoreboard_pend_counter.sv
// rf_scoreboard_pend_counter: per-register pending-write counter with same-cycle writeback bypass
// ports: clk/rst/en control; inc = issue write, dec = writeback; eff_nz/eff_full = bypassed count flags,
// nxt_nz = post-update count nonzero, uf = writeback against an empty counter
module rf_scoreboard_pend_counter
  import rf_scoreboard_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic inc,
  input  logic dec,
  output logic eff_nz,
  output logic eff_full,
  output logic nxt_nz,
  output logic uf
);
  logic [CNT_WIDTH-1:0] cnt, eff, nxt;
  always_comb begin
    eff = cnt - CNT_WIDTH'(dec && cnt != '0);
    nxt = (inc && eff != '1) ? eff + CNT_WIDTH'(1) : eff;
  end
  assign eff_nz = eff != '0;
  assign eff_full = &eff;
  assign nxt_nz = nxt != '0;
  assign uf = dec && cnt == '0;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (en) cnt <= nxt;
endmodule

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: register hazard tracking, issue grant and branch-shadow stall control
// ports: I_CLOCK/I_RESET/I_LOCK control; I_Src*/I_Dest*/I_IsBranch describe the decode instruction;
// I_WriteBack* retire writes; O_IssueGrant/O_DepStallSignal/O_BranchStallSignal are combinational,
// O_PendingMask and sticky O_Underflow are registered
module rf_scoreboard
  import rf_scoreboard_pkg::*;
(
  input  logic                 I_CLOCK,
  input  logic                 I_RESET,
  input  logic                 I_LOCK,
  input  logic                 I_IssueValid,
  input  logic                 I_Src1Used,
  input  logic [IDX_WIDTH-1:0] I_Src1Idx,
  input  logic                 I_Src2Used,
  input  logic [IDX_WIDTH-1:0] I_Src2Idx,
  input  logic                 I_DestUsed,
  input  logic [IDX_WIDTH-1:0] I_DestIdx,
  input  logic                 I_IsBranch,
  input  logic                 I_WriteBackEnable,
  input  logic [IDX_WIDTH-1:0] I_WriteBackRegIdx,
  input  logic                 I_BranchResolved,
  output logic                 O_IssueGrant,
  output logic                 O_DepStallSignal,
  output logic                 O_BranchStallSignal,
  output logic [NUM_RF-1:0]    O_PendingMask,
  output logic                 O_Underflow
);
  logic [0:0] state;
  logic [NUM_RF-1:0] eff_nz, eff_full, nxt_nz, uf, inc, dec;
  logic act, raw, full, drain;
  for (genvar g = 0; g < NUM_RF; g++) begin : g_cnt
    assign inc[g] = O_IssueGrant && I_DestUsed && I_DestIdx == IDX_WIDTH'(g);
    assign dec[g] = I_WriteBackEnable && I_WriteBackRegIdx == IDX_WIDTH'(g);
    rf_scoreboard_pend_counter u_cnt (
      .clk(I_CLOCK), .rst(I_RESET), .en(I_LOCK), .inc(inc[g]), .dec(dec[g]),
      .eff_nz(eff_nz[g]), .eff_full(eff_full[g]), .nxt_nz(nxt_nz[g]), .uf(uf[g])
    );
  end
  always_comb begin
    act = I_LOCK && I_IssueValid && state == SB_IDLE;
    raw = (I_Src1Used && eff_nz[I_Src1Idx]) || (I_Src2Used && eff_nz[I_Src2Idx]);
    full = I_DestUsed && eff_full[I_DestIdx];
    // condition codes are only trustworthy once every in-flight write has retired
    drain = I_IsBranch && |eff_nz;
    O_DepStallSignal = act && (raw || full || drain);
    O_IssueGrant = act && !O_DepStallSignal;
    O_BranchStallSignal = I_LOCK && (state == SB_BR_WAIT || (I_IssueValid && I_IsBranch));
  end
  always_ff @(posedge I_CLOCK)
    if (I_RESET) begin
      state <= SB_IDLE;
      O_PendingMask <= '0;
      O_Underflow <= 1'b0;
    end else if (I_LOCK) begin
      state <= (state == SB_IDLE) ? ((O_IssueGrant && I_IsBranch) ? SB_BR_WAIT : SB_IDLE)
                                  : (I_BranchResolved ? SB_IDLE : SB_BR_WAIT);
      O_PendingMask <= nxt_nz;
      O_Underflow <= O_Underflow | (|uf);
    end
endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed and randomized checks of rf_scoreboard against a behavioural model
module tb_rf_scoreboard;
  logic clk = 1'b0;
  logic rst, lock, iv, s1u, s2u, du, br, wb, res;
  logic [3:0] s1, s2, d, wbi;
  logic grant, dep, bst, uf;
  logic [15:0] mask;
  logic lg, ld, lb, lu;
  logic [15:0] lm;
  int n_cmp = 0, n_bad = 0;
  int cnt[16];
  bit bw, muf;

  always #5 clk = ~clk;

  rf_scoreboard dut (
    .I_CLOCK(clk), .I_RESET(rst), .I_LOCK(lock), .I_IssueValid(iv),
    .I_Src1Used(s1u), .I_Src1Idx(s1), .I_Src2Used(s2u), .I_Src2Idx(s2),
    .I_DestUsed(du), .I_DestIdx(d), .I_IsBranch(br),
    .I_WriteBackEnable(wb), .I_WriteBackRegIdx(wbi), .I_BranchResolved(res),
    .O_IssueGrant(grant), .O_DepStallSignal(dep), .O_BranchStallSignal(bst),
    .O_PendingMask(mask), .O_Underflow(uf)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic int eff(input int r);
    return cnt[r] - ((wb && int'(wbi) == r && cnt[r] > 0) ? 1 : 0);
  endfunction

  task automatic idle();
    {rst, iv, s1u, s2u, du, br, wb, res} = '0;
    lock = 1'b1;
    {s1, s2, d, wbi} = '0;
  endtask

  task automatic model_reset();
    foreach (cnt[r]) cnt[r] = 0;
    bw = 0;
    muf = 0;
  endtask

  // One cycle: compare at negedge against the model, then advance the model across the posedge.
  task automatic cycle();
    bit act, raw, full, drain, e_dep, e_grant, e_bst;
    logic [15:0] e_mask;
    @(negedge clk);
    act = lock && iv && !bw;
    raw = (s1u && eff(int'(s1)) != 0) || (s2u && eff(int'(s2)) != 0);
    full = du && eff(int'(d)) == 3;
    drain = 0;
    for (int r = 0; r < 16; r++) if (eff(r) != 0) drain = br;
    e_dep = act && (raw || full || drain);
    e_grant = act && !e_dep;
    e_bst = lock && (bw || (iv && br));
    for (int r = 0; r < 16; r++) e_mask[r] = cnt[r] != 0;
    chk("grant", {31'b0, grant}, {31'b0, e_grant});
    chk("depstall", {31'b0, dep}, {31'b0, e_dep});
    chk("brstall", {31'b0, bst}, {31'b0, e_bst});
    chk("mask", {16'b0, mask}, {16'b0, e_mask});
    chk("underflow", {31'b0, uf}, {31'b0, muf});
    lg = grant; ld = dep; lb = bst; lu = uf; lm = mask;
    @(posedge clk);
    if (rst) model_reset();
    else if (lock) begin
      if (wb) begin
        if (cnt[wbi] == 0) muf = 1;
        else cnt[wbi]--;
      end
      if (e_grant && du) cnt[d]++;
      bw = bw ? !res : (e_grant && br);
    end
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    idle();
    cycle();
    chk("rst_mask", {16'b0, lm}, 32'h0);
    chk("rst_uf", {31'b0, lu}, 32'h0);
    chk("rst_grant", {31'b0, lg}, 32'h0);
    // ADD R1 <- R2, R3
    iv = 1; du = 1; d = 1; s1u = 1; s1 = 2; s2u = 1; s2 = 3;
    cycle();
    chk("add_grant", {31'b0, lg}, 32'h1);
    chk("add_dep", {31'b0, ld}, 32'h0);
    idle(); cycle();
    chk("add_mask", {16'b0, lm}, 32'h0002);
    // RAW on R1, then same-cycle writeback bypass
    iv = 1; s1u = 1; s1 = 1;
    cycle();
    chk("raw_dep", {31'b0, ld}, 32'h1);
    chk("raw_grant", {31'b0, lg}, 32'h0);
    wb = 1; wbi = 1;
    cycle();
    chk("byp_grant", {31'b0, lg}, 32'h1);
    chk("byp_dep", {31'b0, ld}, 32'h0);
    idle(); cycle();
    chk("byp_mask", {16'b0, lm}, 32'h0);
    // Fill R4 to saturation
    iv = 1; du = 1; d = 4;
    repeat (3) begin
      cycle();
      chk("fill_grant", {31'b0, lg}, 32'h1);
    end
    cycle();
    chk("full_dep", {31'b0, ld}, 32'h1);
    idle(); wb = 1; wbi = 4; cycle();
    idle(); iv = 1; du = 1; d = 4; wb = 1; wbi = 4;
    cycle();
    chk("gw_grant", {31'b0, lg}, 32'h1);
    idle(); iv = 1; du = 1; d = 4; wb = 1; wbi = 4;
    cycle();
    chk("gw2_grant", {31'b0, lg}, 32'h1);
    idle(); wb = 1; wbi = 4; cycle(); cycle();
    idle(); cycle();
    chk("drain4_mask", {16'b0, lm}, 32'h0);
    chk("drain4_uf", {31'b0, lu}, 32'h0);
    // Branch drain and branch shadow
    iv = 1; du = 1; d = 5; cycle();
    idle(); iv = 1; br = 1;
    cycle();
    chk("br_dep", {31'b0, ld}, 32'h1);
    chk("br_stall", {31'b0, lb}, 32'h1);
    wb = 1; wbi = 5;
    cycle();
    chk("br_grant", {31'b0, lg}, 32'h1);
    idle(); iv = 1;
    cycle();
    chk("shadow_stall", {31'b0, lb}, 32'h1);
    chk("shadow_grant", {31'b0, lg}, 32'h0);
    cycle();
    res = 1;
    cycle();
    chk("res_grant", {31'b0, lg}, 32'h0);
    res = 0;
    cycle();
    chk("post_res_grant", {31'b0, lg}, 32'h1);
    // Underflow
    idle(); wb = 1; wbi = 9; cycle();
    idle(); cycle();
    chk("uf_set", {31'b0, lu}, 32'h1);
    cycle();
    chk("uf_hold", {31'b0, lu}, 32'h1);
    // Reset in branch shadow with R7 pending (JSR)
    iv = 1; br = 1; du = 1; d = 7; cycle();
    idle(); rst = 1; cycle();
    idle(); cycle();
    chk("rst2_mask", {16'b0, lm}, 32'h0);
    chk("rst2_uf", {31'b0, lu}, 32'h0);
    chk("rst2_bst", {31'b0, lb}, 32'h0);
    // Pipeline freeze
    iv = 1; du = 1; d = 3; cycle();
    lock = 0; wb = 1; wbi = 3;
    cycle();
    chk("lock_grant", {31'b0, lg}, 32'h0);
    chk("lock_dep", {31'b0, ld}, 32'h0);
    chk("lock_bst", {31'b0, lb}, 32'h0);
    idle(); cycle();
    chk("lock_mask", {16'b0, lm}, 32'h0008);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 199) == 0;
      lock = $urandom_range(0, 9) != 0;
      iv = $urandom_range(0, 3) != 0;
      s1u = $urandom_range(0, 1) == 1;
      s2u = $urandom_range(0, 1) == 1;
      du = $urandom_range(0, 2) != 0;
      br = $urandom_range(0, 7) == 0;
      wb = $urandom_range(0, 1) == 1;
      res = $urandom_range(0, 3) == 0;
      s1 = 4'($urandom_range(0, 4));
      s2 = 4'($urandom_range(0, 4));
      d = 4'($urandom_range(0, 4));
      wbi = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 4));
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
